// File: rtl/z88_bus_pkg.sv
// Shared types and constants for the Z88 bus glue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package z88_bus_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bus_state_e;

    localparam int SLOT_RAM = 0;
    localparam int SLOT_ROM = 1;

    // Width needed to hold a slot index; never narrower than one bit.
    function automatic int slot_idx_w(input int nslot);
        return (nslot > 1) ? $clog2(nslot) : 1;
    endfunction

endpackage

// File: rtl/z88_ena_ring.sv
// One-hot clock-enable ring, rotating one position left per clock.
// Latency: one clock per position; a full ring takes N clocks.
// Backpressure: none, the ring free-runs regardless of bus state.
module z88_ena_ring #(
    parameter int N = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    output logic [N-1:0] ena_o
);

    logic [N-1:0] ring_q;

    // Rotate left; the top bit wraps back into bit 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ring_q <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            ring_q <= {ring_q[N-2:0], ring_q[N-1]};
        end
    end

    assign ena_o = ring_q;

endmodule

// File: rtl/z88_busglue.sv
// Z88 bus glue: enable ring, slot decode, wait-state stretch and read latches.
// Latency: read data latched on the sample strobe, or W rings later for a W-wait slot.
// Backpressure: a wait stretch holds cpu_cen low until the stretched capture completes.
module z88_busglue
    import z88_bus_pkg::*;
#(
    parameter int ENA_PHASES = 5,
    parameter int NSLOT      = 4,
    parameter int DW         = 8,
    parameter int WAIT_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [ENA_PHASES-1:0]   clk_ena,
    output logic                    cpu_cen,
    input  logic                    cpu_owner,
    input  logic [NSLOT-1:0]        cs_n,
    input  logic [NSLOT*WAIT_W-1:0] slot_wait,
    input  logic [NSLOT*DW-1:0]     mem_do,
    input  logic [DW-1:0]           io_do,
    input  logic [DW-1:0]           cpu_dout,
    output logic [DW-1:0]           mem_di,
    output logic [DW-1:0]           cpu_di,
    output logic [DW-1:0]           lcd_di,
    output logic                    busy,
    output logic                    cs_err
);

    localparam int SW = slot_idx_w(NSLOT);

    logic [ENA_PHASES-1:0] ring;
    logic                  sample;
    logic                  commit;

    bus_state_e            state_q;
    logic [WAIT_W-1:0]     wcnt_q;
    logic [SW-1:0]         slot_q;
    logic                  owner_q;
    logic                  busy_q;
    logic                  cs_err_q;
    logic [DW-1:0]         cpu_di_q;
    logic [DW-1:0]         lcd_di_q;
    logic [DW-1:0]         mem_di_q;

    logic                  sel_vld;
    logic [SW-1:0]         sel_idx;
    logic                  multi_sel;
    logic [WAIT_W-1:0]     sel_wait;

    logic                  cap_en;
    logic                  cap_vld;
    logic                  cap_owner;
    logic [SW-1:0]         cap_slot;
    logic [DW-1:0]         cap_mem;

    z88_ena_ring #(.N(ENA_PHASES)) u_ring (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .ena_o  (ring)
    );

    assign sample = ring[ENA_PHASES-2];
    assign commit = ring[ENA_PHASES-1];

    // Slot decode: lowest active-low select wins; any further low bit is a conflict.
    always_comb begin
        sel_vld   = 1'b0;
        sel_idx   = '0;
        multi_sel = 1'b0;
        for (int i = SLOT_RAM; i < NSLOT; i++) begin
            if (!cs_n[i]) begin
                if (sel_vld) begin
                    multi_sel = 1'b1;
                end else begin
                    sel_vld = 1'b1;
                    sel_idx = SW'(i);
                end
            end
        end
    end

    assign sel_wait = sel_vld ? slot_wait[sel_idx*WAIT_W +: WAIT_W] : '0;

    // Capture source: live decode when idle, the held slot/owner at the end of a stretch.
    always_comb begin
        cap_slot  = sel_idx;
        cap_vld   = sel_vld;
        cap_owner = cpu_owner;
        cap_en    = 1'b0;
        if (state_q == ST_WAIT) begin
            cap_slot  = slot_q;
            cap_vld   = 1'b1;
            cap_owner = owner_q;
            cap_en    = sample && (wcnt_q == WAIT_W'(1));
        end else begin
            cap_en    = sample && !(sel_vld && (sel_wait != '0));
        end
        cap_mem = mem_do[cap_slot*DW +: DW];
    end

    // Bus FSM: decide capture or stretch on each sample strobe; selects are ignored while stretching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            slot_q   <= '0;
            owner_q  <= 1'b0;
            busy_q   <= 1'b0;
            cs_err_q <= 1'b0;
            cpu_di_q <= '0;
            lcd_di_q <= '0;
        end else if (sample) begin
            if (cap_en) begin
                if (cap_owner) begin
                    cpu_di_q <= cap_vld ? cap_mem : io_do;
                end else begin
                    lcd_di_q <= cap_vld ? cap_mem : '0;
                end
            end
            unique case (state_q)
                ST_IDLE: begin
                    owner_q <= cpu_owner;
                    if (multi_sel) begin
                        cs_err_q <= 1'b1;
                    end
                    if (sel_vld && (sel_wait != '0)) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= sel_wait;
                        slot_q  <= sel_idx;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == WAIT_W'(1)) begin
                        state_q <= ST_IDLE;
                        wcnt_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        wcnt_q  <= wcnt_q - WAIT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write data is a plain one-clock delay of the CPU output bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_di_q <= '0;
        end else begin
            mem_di_q <= cpu_dout;
        end
    end

    // owner_q is zero from reset, so no CPU enable can appear before the first sampled cycle.
    assign cpu_cen = commit & owner_q & ~busy_q;
    assign clk_ena = ring;
    assign busy    = busy_q;
    assign cs_err  = cs_err_q;
    assign cpu_di  = cpu_di_q;
    assign lcd_di  = lcd_di_q;
    assign mem_di  = mem_di_q;

endmodule

// File: tb/tb_z88_busglue.sv
module tb_z88_busglue;

    localparam int N  = 5;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int WW = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     clk_ena;
    logic             cpu_cen;
    logic             cpu_owner;
    logic [NS-1:0]    cs_n;
    logic [NS*WW-1:0] slot_wait;
    logic [NS*DW-1:0] mem_do;
    logic [DW-1:0]    io_do;
    logic [DW-1:0]    cpu_dout;
    logic [DW-1:0]    mem_di;
    logic [DW-1:0]    cpu_di;
    logic [DW-1:0]    lcd_di;
    logic             busy;
    logic             cs_err;

    always #5 clk = ~clk;

    z88_busglue #(.ENA_PHASES(N), .NSLOT(NS), .DW(DW), .WAIT_W(WW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_ena   (clk_ena),
        .cpu_cen   (cpu_cen),
        .cpu_owner (cpu_owner),
        .cs_n      (cs_n),
        .slot_wait (slot_wait),
        .mem_do    (mem_do),
        .io_do     (io_do),
        .cpu_dout  (cpu_dout),
        .mem_di    (mem_di),
        .cpu_di    (cpu_di),
        .lcd_di    (lcd_di),
        .busy      (busy),
        .cs_err    (cs_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase counter plus an absolute-cycle deadline for stretched captures.
    int          m_phase;
    int          m_cyc;
    int          m_end;
    bit          m_stretch;
    int          m_slot;
    bit          m_owner;
    bit          m_err;
    logic [DW-1:0] m_cpu_di;
    logic [DW-1:0] m_lcd_di;
    logic [DW-1:0] m_mem_di;

    task automatic m_reset();
        m_phase = 0; m_cyc = 0; m_end = 0; m_stretch = 0; m_slot = 0;
        m_owner = 0; m_err = 0; m_cpu_di = '0; m_lcd_di = '0; m_mem_di = '0;
    endtask

    task automatic m_capture(input int s, input bit own);
        logic [DW-1:0] d;
        if (s < 0) d = own ? io_do : '0;
        else       d = mem_do[s*DW +: DW];
        if (own) m_cpu_di = d;
        else     m_lcd_di = d;
    endtask

    // Advance model and DUT by one clock; inputs must already be stable.
    task automatic step();
        int s;
        int w;
        int lows;
        if (m_phase == N-2) begin
            if (m_stretch) begin
                if (m_cyc == m_end) begin
                    m_capture(m_slot, m_owner);
                    m_stretch = 0;
                end
            end else begin
                s = -1; lows = 0;
                for (int i = 0; i < NS; i++) begin
                    if (!cs_n[i]) begin
                        lows++;
                        if (s < 0) s = i;
                    end
                end
                if (lows >= 2) m_err = 1;
                m_owner = cpu_owner;
                w = (s < 0) ? 0 : int'(slot_wait[s*WW +: WW]);
                if (w == 0) begin
                    m_capture(s, cpu_owner);
                end else begin
                    m_stretch = 1;
                    m_slot    = s;
                    m_end     = m_cyc + w*N;
                end
            end
        end
        m_mem_di = cpu_dout;
        m_phase  = (m_phase + 1) % N;
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to_sample();
        for (int k = 0; k < N && m_phase != N-2; k++) step();
    endtask

    task automatic test_reset();
        logic [N-1:0] seq [6];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        reset_n = 1'b0; cpu_owner = 1'b1; cs_n = '1; slot_wait = '0;
        mem_do = '0; io_do = '0; cpu_dout = 8'h5E;
        m_reset();
        #12;
        n_cmp++; if (clk_ena !== 5'b00001) begin n_fail++; $display("FAIL reset clk_ena got=%b exp=00001", clk_ena); end
        n_cmp++; if ({cpu_cen, busy, cs_err} !== 3'b000) begin n_fail++; $display("FAIL reset flags got=%b exp=000", {cpu_cen, busy, cs_err}); end
        n_cmp++; if ({cpu_di, lcd_di, mem_di} !== 24'h0) begin n_fail++; $display("FAIL reset data got=%h exp=000000", {cpu_di, lcd_di, mem_di}); end
        @(negedge clk);
        cpu_dout = '0;
        reset_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            n_cmp++; if (clk_ena !== seq[k]) begin n_fail++; $display("FAIL ring_seq k=%0d got=%b exp=%b", k, clk_ena, seq[k]); end
            n_cmp++; if (cpu_cen !== (k == 4)) begin n_fail++; $display("FAIL first_cen k=%0d got=%b exp=%b", k, cpu_cen, (k == 4)); end
            if (k < 5) step();
        end
    endtask

    task automatic test_slot0();
        bit saw_busy = 0;
        cs_n = 4'b1110; slot_wait = '0; mem_do = {8'h11, 8'h22, 8'h33, 8'hA5}; cpu_owner = 1'b1;
        run_to_sample();
        step();
        n_cmp++; if (cpu_di !== 8'hA5) begin n_fail++; $display("FAIL slot0 cpu_di got=%h exp=a5", cpu_di); end
        if (busy) saw_busy = 1;
        for (int k = 0; k < 2*N; k++) begin
            step();
            if (busy) saw_busy = 1;
        end
        n_cmp++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL slot0 busy got=%b exp=0", saw_busy); end
    endtask

    task automatic test_wait();
        int busy_cnt = 0;
        int cen_cnt  = 0;
        int com_cnt  = 0;
        cs_n = 4'b1101; slot_wait = 8'b00_00_10_00; mem_do = {8'h44, 8'h55, 8'h3C, 8'h66}; cpu_owner = 1'b1;
        run_to_sample();
        step();
        for (int k = 0; k < 30 && busy === 1'b1; k++) begin
            busy_cnt++;
            if (clk_ena[N-1]) com_cnt++;
            if (cpu_cen) cen_cnt++;
            if (k == 3) cs_n = 4'b1110;
            step();
        end
        n_cmp++; if (busy_cnt !== 10) begin n_fail++; $display("FAIL wait busy_len got=%0d exp=10", busy_cnt); end
        n_cmp++; if (com_cnt !== 2 || cen_cnt !== 0) begin n_fail++; $display("FAIL wait cen_suppress commits=%0d pulses=%0d exp=2/0", com_cnt, cen_cnt); end
        n_cmp++; if (cpu_di !== 8'h3C) begin n_fail++; $display("FAIL wait cpu_di got=%h exp=3c", cpu_di); end
        n_cmp++; if (cpu_cen !== 1'b1) begin n_fail++; $display("FAIL wait cen_after got=%b exp=1", cpu_cen); end
        cs_n = '1;
    endtask

    task automatic test_none();
        cpu_owner = 1'b0; cs_n = 4'b1110; slot_wait = '0; mem_do = {8'h01, 8'h02, 8'h03, 8'h5A};
        run_to_sample();
        step();
        n_cmp++; if (lcd_di !== 8'h5A || cpu_di !== 8'h3C) begin n_fail++; $display("FAIL lcd_slot got=%h/%h exp=5a/3c", lcd_di, cpu_di); end
        n_cmp++; if (cpu_cen !== 1'b0) begin n_fail++; $display("FAIL lcd_cen got=%b exp=0", cpu_cen); end
        cs_n = 4'b1111; io_do = 8'h77; cpu_owner = 1'b1;
        run_to_sample();
        step();
        n_cmp++; if (cpu_di !== 8'h77) begin n_fail++; $display("FAIL none_cpu got=%h exp=77", cpu_di); end
        cpu_owner = 1'b0;
        run_to_sample();
        step();
        n_cmp++; if (lcd_di !== 8'h00 || cpu_di !== 8'h77) begin n_fail++; $display("FAIL none_lcd got=%h/%h exp=00/77", lcd_di, cpu_di); end
    endtask

    task automatic test_multi();
        n_cmp++; if (cs_err !== 1'b0) begin n_fail++; $display("FAIL multi pre_err got=%b exp=0", cs_err); end
        cs_n = 4'b1100; slot_wait = 8'b00_00_01_00; mem_do = {8'hAA, 8'hBB, 8'h99, 8'hC3}; cpu_owner = 1'b1;
        run_to_sample();
        step();
        n_cmp++; if (cpu_di !== 8'hC3 || busy !== 1'b0) begin n_fail++; $display("FAIL multi capture got=%h busy=%b exp=c3/0", cpu_di, busy); end
        n_cmp++; if (cs_err !== 1'b1) begin n_fail++; $display("FAIL multi err got=%b exp=1", cs_err); end
        cs_n = 4'b1111; io_do = 8'h12;
        for (int k = 0; k < 2*N; k++) step();
        n_cmp++; if (cs_err !== 1'b1) begin n_fail++; $display("FAIL multi sticky got=%b exp=1", cs_err); end
    endtask

    task automatic test_reset_mid_wait();
        cs_n = 4'b1011; slot_wait = 8'b00_11_00_00; mem_do = {8'h10, 8'hE7, 8'h20, 8'h30};
        cpu_owner = 1'b1; cpu_dout = 8'hF0;
        run_to_sample();
        step();
        for (int k = 0; k < 4; k++) step();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait busy_pre got=%b exp=1", busy); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (clk_ena !== 5'b00001 || {cpu_cen, busy, cs_err} !== 3'b000) begin n_fail++; $display("FAIL rst_wait ctrl got=%b/%b exp=00001/000", clk_ena, {cpu_cen, busy, cs_err}); end
        n_cmp++; if ({cpu_di, lcd_di, mem_di} !== 24'h0) begin n_fail++; $display("FAIL rst_wait data got=%h exp=000000", {cpu_di, lcd_di, mem_di}); end
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cs_n = 4'b1110; slot_wait = '0; mem_do = {8'h10, 8'hE7, 8'h20, 8'h4B};
        run_to_sample();
        step();
        n_cmp++; if (cpu_di !== 8'h4B || busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait post got=%h busy=%b exp=4b/0", cpu_di, busy); end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        for (int k = 0; k < 800; k++) begin
            mem_do    = $urandom;
            io_do     = DW'($urandom);
            cpu_dout  = DW'($urandom);
            slot_wait = (NS*WW)'($urandom);
            cpu_owner = 1'($urandom);
            if (!m_stretch) cs_n = NS'($urandom);
            step();
            exp_r = '0;
            exp_r[m_phase] = 1'b1;
            n_cmp++; if (clk_ena !== exp_r) begin n_fail++; $display("FAIL rand clk_ena cyc=%0d got=%b exp=%b", m_cyc, clk_ena, exp_r); end
            n_cmp++; if (cpu_cen !== (m_phase == N-1 && m_owner && !m_stretch)) begin n_fail++; $display("FAIL rand cpu_cen cyc=%0d got=%b", m_cyc, cpu_cen); end
            n_cmp++; if (busy !== m_stretch) begin n_fail++; $display("FAIL rand busy cyc=%0d got=%b exp=%b", m_cyc, busy, m_stretch); end
            n_cmp++; if (cs_err !== m_err) begin n_fail++; $display("FAIL rand cs_err cyc=%0d got=%b exp=%b", m_cyc, cs_err, m_err); end
            n_cmp++; if (cpu_di !== m_cpu_di) begin n_fail++; $display("FAIL rand cpu_di cyc=%0d got=%h exp=%h", m_cyc, cpu_di, m_cpu_di); end
            n_cmp++; if (lcd_di !== m_lcd_di) begin n_fail++; $display("FAIL rand lcd_di cyc=%0d got=%h exp=%h", m_cyc, lcd_di, m_lcd_di); end
            n_cmp++; if (mem_di !== m_mem_di) begin n_fail++; $display("FAIL rand mem_di cyc=%0d got=%h exp=%h", m_cyc, mem_di, m_mem_di); end
        end
    endtask

    initial begin
        test_reset();
        test_slot0();
        test_wait();
        test_none();
        test_multi();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
